// File: rtl/imem_sync_if.sv
// Bundle of fetch, loader and status signals for imem_sync.
// The master side drives requests and loader writes; the slave side is the memory.
`timescale 1ns/1ps
interface imem_sync_if #(
    parameter int unsigned DEPTH = 64
) ();
    localparam int unsigned AW = $clog2(DEPTH);

    logic          fetch_req;
    logic [31:0]   fetch_addr;
    logic          fetch_stall;
    logic          fetch_ready;
    logic          fetch_valid;
    logic [31:0]   fetch_data;
    logic          fetch_fault;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic          load_done;
    logic          mode_run;
    logic [31:0]   fetch_count;

    modport master (
        output fetch_req, fetch_addr, fetch_stall,
        output load_en, load_addr, load_data, load_done,
        input  fetch_ready, fetch_valid, fetch_data, fetch_fault,
        input  mode_run, fetch_count
    );

    modport slave (
        input  fetch_req, fetch_addr, fetch_stall,
        input  load_en, load_addr, load_data, load_done,
        output fetch_ready, fetch_valid, fetch_data, fetch_fault,
        output mode_run, fetch_count
    );
endinterface

// File: rtl/imem_sync.sv
// Instruction memory with a LOAD phase (loader writes words) and a RUN phase
// (one-cycle-latency fetches with alignment/range fault reporting).
`timescale 1ns/1ps
module imem_sync #(
    parameter int unsigned DEPTH         = 64,
    parameter logic [31:0] START_ADDRESS = 32'h0000_0000,
    parameter bit          BOOT_LOAD     = 1'b1,
    parameter logic [31:0] NOP_WORD      = 32'h0000_0013
) (
    input logic        clk,
    input logic        reset,
    imem_sync_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam state_e BOOT_STATE = BOOT_LOAD ? S_LOAD : S_RUN;

    state_e        state_q, state_d;
    logic          fetch_valid_q, fetch_valid_d;
    logic [31:0]   fetch_data_q, fetch_data_d;
    logic          fetch_fault_q, fetch_fault_d;
    logic [31:0]   fetch_count_q, fetch_count_d;

    logic [31:0]   mem [DEPTH];

    logic          hold;
    logic          ready;
    logic          accept;
    logic [29:0]   word_idx;
    logic [AW-1:0] rd_idx;
    logic          req_fault;

    // NOTE: the memory array has no reset; its contents survive reset and it maps onto RAM.
    always_ff @(posedge clk) begin
        if (!reset && state_q == S_LOAD && bus.load_en) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= BOOT_STATE;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= NOP_WORD;
            fetch_fault_q <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_data_q  <= fetch_data_d;
            fetch_fault_q <= fetch_fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_LOAD && bus.load_done) begin
            state_d = S_RUN;
        end
    end

    // Addresses below START_ADDRESS wrap to a huge index and land in the range fault.
    assign word_idx  = 30'((bus.fetch_addr - START_ADDRESS) >> 2);
    assign rd_idx    = word_idx[AW-1:0];
    assign req_fault = (bus.fetch_addr[1:0] != 2'b00) || (word_idx >= 30'(DEPTH));

    assign hold   = fetch_valid_q && bus.fetch_stall;
    assign ready  = (state_q == S_RUN) && !hold;
    assign accept = bus.fetch_req && ready;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        fetch_valid_d = fetch_valid_q;
        fetch_data_d  = fetch_data_q;
        fetch_fault_d = fetch_fault_q;
        fetch_count_d = fetch_count_q;
        if (accept) begin
            fetch_valid_d = 1'b1;
            fetch_fault_d = req_fault;
            fetch_data_d  = req_fault ? NOP_WORD : mem[rd_idx];
            fetch_count_d = fetch_count_q + 32'd1;
        end else if (!hold) begin
            fetch_valid_d = 1'b0;
        end
    end

    assign bus.fetch_ready = ready;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_data  = fetch_data_q;
    assign bus.fetch_fault = fetch_fault_q;
    assign bus.mode_run    = (state_q == S_RUN);
    assign bus.fetch_count = fetch_count_q;
endmodule

// File: tb/tb_imem_sync.sv
// Scoreboard bench for imem_sync: a high-level model predicts each fetch result,
// and an independent monitor pops and compares whenever the DUT presents one.
`timescale 1ns/1ps
module tb_imem_sync;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] data;
        logic        fault;
    } resp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    imem_sync_if #(.DEPTH(DEPTH)) bus ();
    imem_sync_if #(.DEPTH(DEPTH)) bus2 ();

    imem_sync #(.DEPTH(DEPTH), .START_ADDRESS(32'h0), .BOOT_LOAD(1'b1), .NOP_WORD(NOP))
        u_dut (.clk(clk), .reset(reset), .bus(bus));

    imem_sync #(.DEPTH(DEPTH), .START_ADDRESS(32'h100), .BOOT_LOAD(1'b0), .NOP_WORD(NOP))
        u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    resp_t       exp_q[$];
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_count;
    bit          m_run;
    bit          m_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare status at the falling edge, advance the model.
    task automatic step(input logic req, input logic [31:0] addr, input logic stall,
                        input logic ld_en, input logic [AW-1:0] ld_addr,
                        input logic [31:0] ld_data, input logic ld_done);
        bit          m_ready, acc, flt;
        logic [31:0] off;
        bus.fetch_req   = req;
        bus.fetch_addr  = addr;
        bus.fetch_stall = stall;
        bus.load_en     = ld_en;
        bus.load_addr   = ld_addr;
        bus.load_data   = ld_data;
        bus.load_done   = ld_done;
        @(negedge clk);
        m_ready = m_run && !(m_valid && stall);
        check("fetch_ready", 32'(bus.fetch_ready), 32'(m_ready));
        check("fetch_valid", 32'(bus.fetch_valid), 32'(m_valid));
        check("mode_run", 32'(bus.mode_run), 32'(m_run));
        check("fetch_count", bus.fetch_count, m_count);
        acc = req && m_ready;
        if (acc) begin
            off = addr - 32'h0;
            flt = (addr[1:0] != 2'b00) || ((off / 4) >= DEPTH);
            exp_q.push_back('{flt ? NOP : m_mem[(off / 4) % DEPTH], flt});
            m_count = m_count + 32'd1;
        end
        m_valid = (m_valid && stall) || acc;
        if (!m_run) begin
            if (ld_en) m_mem[ld_addr] = ld_data;
            if (ld_done) m_run = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0, 1'b0);
    endtask

    task automatic fetch(input logic [31:0] addr);
        step(1'b1, addr, 1'b0, 1'b0, '0, 32'h0, 1'b0);
    endtask

    task automatic do_reset(input logic req, input logic [31:0] addr, input logic ld_en,
                            input logic [AW-1:0] ld_addr, input logic [31:0] ld_data);
        bus.fetch_req   = req;
        bus.fetch_addr  = addr;
        bus.fetch_stall = 1'b0;
        bus.load_en     = ld_en;
        bus.load_addr   = ld_addr;
        bus.load_data   = ld_data;
        bus.load_done   = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.fetch_req = 1'b0;
        bus.load_en   = 1'b0;
        m_run   = 1'b0;
        m_valid = 1'b0;
        m_count = 32'd0;
        exp_q.delete();
    endtask

    task automatic post_reset_checks();
        @(negedge clk);
        check("rst_valid", 32'(bus.fetch_valid), 32'd0);
        check("rst_data", bus.fetch_data, NOP);
        check("rst_fault", 32'(bus.fetch_fault), 32'd0);
        check("rst_count", bus.fetch_count, 32'd0);
        check("rst_mode", 32'(bus.mode_run), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch2(input logic [31:0] addr, input logic exp_fault);
        bus2.fetch_req  = 1'b1;
        bus2.fetch_addr = addr;
        @(negedge clk);
        check("i2_ready", 32'(bus2.fetch_ready), 32'd1);
        @(posedge clk);
        #1;
        bus2.fetch_req = 1'b0;
        @(negedge clk);
        check("i2_valid", 32'(bus2.fetch_valid), 32'd1);
        check("i2_fault", 32'(bus2.fetch_fault), 32'(exp_fault));
        if (exp_fault) check("i2_nop", bus2.fetch_data, NOP);
        @(posedge clk);
        #1;
    endtask

    // Monitor: new results are popped from the scoreboard; held or idle outputs must keep the last value.
    initial begin : monitor
        resp_t last, r;
        bit    held_prev;
        last = '{NOP, 1'b0};
        held_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.fetch_valid) begin
                    if (held_prev) begin
                        check("hold_data", bus.fetch_data, last.data);
                        check("hold_fault", 32'(bus.fetch_fault), 32'(last.fault));
                    end else if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_result: got valid=1 data=%h, expected no result", bus.fetch_data);
                    end else begin
                        r = exp_q.pop_front();
                        check("result_data", bus.fetch_data, r.data);
                        check("result_fault", 32'(bus.fetch_fault), 32'(r.fault));
                        last = r;
                    end
                end else begin
                    check("idle_data", bus.fetch_data, last.data);
                    check("idle_fault", 32'(bus.fetch_fault), 32'(last.fault));
                end
            end
            held_prev = bus.fetch_valid && bus.fetch_stall;
            if (reset) begin
                last = '{NOP, 1'b0};
                held_prev = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected the run to finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [31:0] words [4];
        logic [31:0] a;
        words[0] = 32'h00f00713;
        words[1] = 32'h00100593;
        words[2] = 32'h3e800513;
        words[3] = 32'h3e800613;
        bus2.fetch_req   = 1'b0;
        bus2.fetch_addr  = 32'h0;
        bus2.fetch_stall = 1'b0;
        bus2.load_en     = 1'b0;
        bus2.load_addr   = '0;
        bus2.load_data   = 32'h0;
        bus2.load_done   = 1'b0;
        bus.fetch_stall  = 1'b0;
        bus.load_done    = 1'b0;

        do_reset(1'b0, 32'h0, 1'b0, '0, 32'h0);
        do_reset(1'b0, 32'h0, 1'b0, '0, 32'h0);
        mon_en = 1'b1;
        post_reset_checks();

        // Second instance: BOOT_LOAD=0 and START_ADDRESS=0x100.
        check("i2_mode_run", 32'(bus2.mode_run), 32'd1);
        fetch2(32'h0FC, 1'b1);
        fetch2(32'h100, 1'b0);
        fetch2(32'h1FC, 1'b0);
        fetch2(32'h200, 1'b1);
        fetch2(32'h102, 1'b1);
        check("i2_count", bus2.fetch_count, 32'd5);

        // Fill memory; fetch attempts while loading must be refused; last write shares the load_done cycle.
        for (int i = 0; i < DEPTH; i++) begin
            step((i % 5) == 0, 32'h0, 1'b0, 1'b1, AW'(i),
                 (i < 4) ? words[i] : $urandom, i == DEPTH - 1);
        end

        fetch(32'h0);
        fetch(32'h4);
        fetch(32'h8);
        fetch(32'hC);
        idle(1);
        check("count_after_4", bus.fetch_count, 32'd4);

        fetch(32'h2);
        fetch(32'h100);
        fetch(32'h101);
        fetch(32'hFFFF_FFFC);
        fetch(32'hFC);
        idle(1);

        // Loader activity in RUN is ignored.
        step(1'b0, 32'h0, 1'b0, 1'b1, '0, 32'hDEADBEEF, 1'b1);
        fetch(32'h0);
        idle(1);

        // Stall holds the output register and blocks new requests.
        fetch(32'h4);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h8, 1'b1, 1'b0, '0, 32'h0, 1'b0);
        step(1'b1, 32'h8, 1'b0, 1'b0, '0, 32'h0, 1'b0);
        idle(1);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                7:       a = 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
                8:       a = 32'(DEPTH * 4 + 4 * $urandom_range(0, 15));
                9:       a = $urandom;
                default: a = 32'(4 * $urandom_range(0, DEPTH - 1));
            endcase
            step($urandom_range(0, 3) != 0, a, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, AW'($urandom), $urandom, $urandom_range(0, 7) == 0);
        end
        idle(1);

        // Reset right after an accepted fetch, with another request in flight.
        fetch(32'h8);
        do_reset(1'b1, 32'hC, 1'b0, '0, 32'h0);
        post_reset_checks();
        // A loader write during reset must be suppressed.
        do_reset(1'b0, 32'h0, 1'b1, AW'(1), 32'hDEAD0001);
        step(1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0, 1'b1);
        fetch(32'h0);
        fetch(32'h4);
        fetch(32'h8);
        fetch(32'hC);
        idle(1);

        // Counter wrap from all ones.
        force u_dut.fetch_count_q = 32'hFFFF_FFFF;
        #1;
        release u_dut.fetch_count_q;
        m_count = 32'hFFFF_FFFF;
        fetch(32'h10);
        idle(1);
        check("count_wrap", bus.fetch_count, 32'd0);

        idle(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/imem_sync.md
IMEM_SYNC -- requirements
Module: imem_sync

Interface
REQ-001 The parameter DEPTH SHALL default to 64 and set the instruction-word count, a power of two from 8 to 4096.
REQ-002 The parameter START_ADDRESS SHALL default to 32'h00000000 and set the byte address of word 0.
REQ-003 The parameter BOOT_LOAD SHALL default to 1; 1 means the block leaves reset in LOAD, 0 means it leaves reset in RUN.
REQ-004 The parameter NOP_WORD SHALL default to 32'h00000013 and set the word returned on a fault and after reset.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 fetch_req  input  1  fetch request.
REQ-008 fetch_addr  input  32  fetch byte address.
REQ-009 fetch_stall  input  1  consumer stall; the output register holds while it is high.
REQ-010 fetch_ready  output  1  a request is accepted this cycle.
REQ-011 fetch_valid  output  1  fetch_data/fetch_fault hold a completed fetch.
REQ-012 fetch_data  output  32  fetched instruction word.
REQ-013 fetch_fault  output  1  the completed fetch was misaligned or out of range.
REQ-014 load_en  input  1  loader write strobe.
REQ-015 load_addr  input  $clog2(DEPTH)  loader word index.
REQ-016 load_data  input  32  loader write word.
REQ-017 load_done  input  1  loader completion pulse.
REQ-018 mode_run  output  1  high in RUN, low in LOAD.
REQ-019 fetch_count  output  32  count of accepted fetches.

Function
REQ-020 The FSM SHALL have two states: LOAD and RUN.
REQ-021 In LOAD, a load_en-high cycle SHALL write load_data to mem[load_addr] at that clock edge.
REQ-022 In LOAD, load_done SHALL move the FSM to RUN on the next edge; load_en and load_done asserted together SHALL perform the write and the transition.
REQ-023 In RUN, load_en and load_done SHALL be ignored and memory SHALL be unchanged.
REQ-024 fetch_ready SHALL equal mode_run AND NOT (fetch_valid AND fetch_stall).
REQ-025 A request is accepted when fetch_req AND fetch_ready; the result SHALL appear one cycle later with fetch_valid high, for a fixed latency of one cycle.
REQ-026 The word index SHALL be (fetch_addr - START_ADDRESS) >> 2, computed as a 32-bit subtraction with wrap-around.
REQ-027 A request SHALL fault when fetch_addr[1:0] != 0 or the word index >= DEPTH; addresses below START_ADDRESS wrap high and therefore fault.
REQ-028 On a fault, fetch_data SHALL be NOP_WORD and fetch_fault SHALL be 1; otherwise fetch_data SHALL be mem[index] and fetch_fault SHALL be 0.
REQ-029 When fetch_valid AND fetch_stall, fetch_valid, fetch_data and fetch_fault SHALL hold unchanged.
REQ-030 When the output register is not held and no request is accepted, fetch_valid SHALL clear to 0 on the next edge; fetch_data and fetch_fault SHALL keep their last values.
REQ-031 fetch_count SHALL increment by 1 per accepted request, including faulting ones, and SHALL wrap from 32'hFFFFFFFF to 0.
REQ-032 A word written in LOAD at edge N SHALL be returned by any fetch accepted after the FSM enters RUN (no read-before-write hazard).
REQ-033 Memory SHALL be a single read port and a single write port; reads and writes never occur in the same state.

Reset
REQ-034 While reset is high at a clock edge, the FSM SHALL go to LOAD if BOOT_LOAD=1, else to RUN.
REQ-035 Reset SHALL force fetch_valid=0, fetch_fault=0, fetch_data=NOP_WORD and fetch_count=0.
REQ-036 Reset SHALL NOT clear memory contents.
REQ-037 Reset asserted mid-fetch or mid-load SHALL discard the in-flight result and suppress the write at that edge; reset has priority over all other inputs.

Verification
REQ-038 Reset with BOOT_LOAD=1; load words 0..3 = 32'h00f00713, 32'h00100593, 32'h3e800513, 32'h3e800613; pulse load_done; fetch 0x0, 0x4, 0x8, 0xC back-to-back -> those four words on consecutive cycles, each one cycle after its request, fetch_fault=0, fetch_count=4.
REQ-039 In RUN, fetch 0x2 -> fetch_data=32'h00000013, fetch_fault=1; fetch DEPTH*4 -> fault; with START_ADDRESS=32'h100, fetch 0x0FC -> fault (wrapped index).
REQ-040 Accept a fetch of 0x4, then hold fetch_stall high 3 cycles -> fetch_valid=1 and data held, fetch_ready=0, fetch_count unchanged; release fetch_stall -> next request is accepted.
REQ-041 In RUN, load_en with load_addr=0 and load_data=32'hDEADBEEF -> a later fetch of 0x0 returns the original word; in LOAD, load_en together with fetch_req -> fetch_ready=0 and fetch_count unchanged.
REQ-042 Assert reset the cycle after a fetch is accepted -> fetch_valid=0, fetch_data=NOP_WORD, fetch_count=0, memory still holds the loaded words; preload fetch_count to 32'hFFFFFFFF, accept one fetch -> fetch_count=0.
